// File: rtl/ring_cntr_decoder.sv
// Ring counter receive-side decoder and monitor.
// Decodes a one-hot (simple ring) code and a Johnson (twisted ring) code to
// binary indices, flags illegal codes, tracks sequence continuity with a
// SYNC/LOCK state machine and keeps a saturating count of sequence errors.
module ring_cntr_decoder #(
    parameter int unsigned N     = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_vld,
    input  logic [N-1:0]              sr_code,
    input  logic [N-1:0]              tr_code,
    output logic                      out_vld,
    output logic [$clog2(N)-1:0]      sr_idx,
    output logic [$clog2(2*N)-1:0]    tr_idx,
    output logic                      sr_ill,
    output logic                      tr_ill,
    output logic                      seq_err,
    output logic                      locked,
    output logic [ERR_W-1:0]          err_cnt
);

    localparam int unsigned SW = $clog2(N);
    localparam int unsigned TW = $clog2(2 * N);
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [N-1:0]     ONES    = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [0:0] {StSync, StLock} state_e;

    state_e           r_state;
    logic             r_out_vld;
    logic [SW-1:0]    r_sr_idx;
    logic [TW-1:0]    r_tr_idx;
    logic             r_sr_ill;
    logic             r_tr_ill;
    logic             r_seq_err;
    logic             r_locked;
    logic [ERR_W-1:0] r_err_cnt;
    logic [SW-1:0]    r_prev_sr;
    logic [TW-1:0]    r_prev_tr;

    logic [CW-1:0]    w_sr_cnt;
    logic [SW-1:0]    w_sr_pos;
    logic             w_sr_ill;
    logic [SW-1:0]    w_sr_idx;
    logic [CW-1:0]    w_tr_cnt;
    logic [CW-1:0]    w_tr_sh;
    logic [N-1:0]     w_tr_lo;
    logic [N-1:0]     w_tr_hi;
    logic             w_tr_ill;
    logic [TW-1:0]    w_tr_idx;
    logic [SW-1:0]    w_sr_nxt;
    logic [TW-1:0]    w_tr_nxt;
    logic             w_in_seq;

    // Simple ring decode: legal only with exactly one bit set.
    always_comb begin
        w_sr_cnt = '0;
        w_sr_pos = '0;
        for (int i = 0; i < N; i++) begin
            if (sr_code[i]) begin
                w_sr_cnt = w_sr_cnt + CW'(1);
                w_sr_pos = SW'(i);
            end
        end
        w_sr_ill = (w_sr_cnt != CW'(1));
        w_sr_idx = w_sr_ill ? '0 : w_sr_pos;
    end

    // Johnson decode: msb=0 means a run of k ones from bit 0, msb=1 a run of k ones from the msb.
    always_comb begin
        w_tr_cnt = '0;
        for (int i = 0; i < N; i++) begin
            if (tr_code[i]) begin
                w_tr_cnt = w_tr_cnt + CW'(1);
            end
        end
        w_tr_sh = CW'(N) - w_tr_cnt;
        w_tr_lo = ~(ONES << w_tr_cnt);
        w_tr_hi = ONES << w_tr_sh;
        if (!tr_code[N-1]) begin
            w_tr_ill = (tr_code != w_tr_lo);
            w_tr_idx = w_tr_ill ? '0 : TW'(w_tr_cnt);
        end else begin
            w_tr_ill = (tr_code != w_tr_hi);
            w_tr_idx = w_tr_ill ? '0 : TW'(32'(2 * N) - 32'(w_tr_cnt));
        end
    end

    // Expected successor of the last accepted indices, with explicit wrap for non-power-of-2 N.
    always_comb begin
        w_sr_nxt = (r_prev_sr == SW'(N - 1))     ? '0 : r_prev_sr + SW'(1);
        w_tr_nxt = (r_prev_tr == TW'(2 * N - 1)) ? '0 : r_prev_tr + TW'(1);
        w_in_seq = !w_sr_ill && !w_tr_ill && (w_sr_idx == w_sr_nxt) && (w_tr_idx == w_tr_nxt);
    end

    // Lock FSM with registered decode outputs, error pulse and saturating error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StSync;
            r_out_vld <= 1'b0;
            r_sr_idx  <= '0;
            r_tr_idx  <= '0;
            r_sr_ill  <= 1'b0;
            r_tr_ill  <= 1'b0;
            r_seq_err <= 1'b0;
            r_locked  <= 1'b0;
            r_err_cnt <= '0;
            r_prev_sr <= '0;
            r_prev_tr <= '0;
        end else begin
            r_out_vld <= in_vld;
            r_seq_err <= 1'b0;
            if (in_vld) begin
                r_sr_idx <= w_sr_idx;
                r_tr_idx <= w_tr_idx;
                r_sr_ill <= w_sr_ill;
                r_tr_ill <= w_tr_ill;
                case (r_state)
                    StSync: begin
                        if (!w_sr_ill && !w_tr_ill) begin
                            r_state   <= StLock;
                            r_locked  <= 1'b1;
                            r_prev_sr <= w_sr_idx;
                            r_prev_tr <= w_tr_idx;
                        end
                    end
                    StLock: begin
                        if (w_in_seq) begin
                            r_prev_sr <= w_sr_idx;
                            r_prev_tr <= w_tr_idx;
                        end else begin
                            // Breaking sample is dropped; relock needs a fresh legal sample.
                            r_state   <= StSync;
                            r_locked  <= 1'b0;
                            r_seq_err <= 1'b1;
                            if (r_err_cnt != ERR_MAX) begin
                                r_err_cnt <= r_err_cnt + ERR_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state  <= StSync;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_vld = r_out_vld;
    assign sr_idx  = r_sr_idx;
    assign tr_idx  = r_tr_idx;
    assign sr_ill  = r_sr_ill;
    assign tr_ill  = r_tr_ill;
    assign seq_err = r_seq_err;
    assign locked  = r_locked;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_ring_cntr_decoder.sv
// Directed bench for ring_cntr_decoder: default instance plus an ERR_W=2 instance
// sharing the same stimulus to exercise error-counter saturation.
module tb_ring_cntr_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_vld = 1'b0;
    logic [3:0] sr_code = '0;
    logic [3:0] tr_code = '0;

    logic       out_vld, sr_ill, tr_ill, seq_err, locked;
    logic [1:0] sr_idx;
    logic [2:0] tr_idx;
    logic [7:0] err_cnt;

    logic       s_out_vld, s_sr_ill, s_tr_ill, s_seq_err, s_locked;
    logic [1:0] s_sr_idx;
    logic [2:0] s_tr_idx;
    logic [1:0] s_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] sr_tab [4];
    logic [3:0] jt_tab [8];

    ring_cntr_decoder #(.N(4), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .sr_code(sr_code), .tr_code(tr_code),
        .out_vld(out_vld), .sr_idx(sr_idx), .tr_idx(tr_idx), .sr_ill(sr_ill),
        .tr_ill(tr_ill), .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
    );

    ring_cntr_decoder #(.N(4), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_vld(in_vld), .sr_code(sr_code), .tr_code(tr_code),
        .out_vld(s_out_vld), .sr_idx(s_sr_idx), .tr_idx(s_tr_idx), .sr_ill(s_sr_ill),
        .tr_ill(s_tr_ill), .seq_err(s_seq_err), .locked(s_locked), .err_cnt(s_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string step, input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: got %0d expected %0d", step, tag, obs, exp);
        end
    endtask

    // Present one sample at the falling edge, then sample outputs 1 ns after the rising edge.
    task automatic drive(input logic v, input logic [3:0] sr, input logic [3:0] tr);
        @(negedge clk);
        rst     = 1'b0;
        in_vld  = v;
        sr_code = sr;
        tr_code = tr;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rst(input logic v, input logic [3:0] sr, input logic [3:0] tr);
        @(negedge clk);
        rst     = 1'b1;
        in_vld  = v;
        sr_code = sr;
        tr_code = tr;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string step, input logic v, input int si, input int ti,
                              input logic sill, input logic till, input logic serr,
                              input logic lk, input int ec, input int ecs);
        chk(step, "out_vld", int'(out_vld), int'(v));
        chk(step, "sr_idx",  int'(sr_idx),  si);
        chk(step, "tr_idx",  int'(tr_idx),  ti);
        chk(step, "sr_ill",  int'(sr_ill),  int'(sill));
        chk(step, "tr_ill",  int'(tr_ill),  int'(till));
        chk(step, "seq_err", int'(seq_err), int'(serr));
        chk(step, "locked",  int'(locked),  int'(lk));
        chk(step, "err_cnt", int'(err_cnt), ec);
        chk(step, "sat_seq_err", int'(s_seq_err), int'(serr));
        chk(step, "sat_err_cnt", int'(s_err_cnt), ecs);
    endtask

    initial begin
        sr_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        jt_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

        // Reset state
        drive_rst(1'b0, 4'b0000, 4'b0000);
        drive_rst(1'b0, 4'b0000, 4'b0000);
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Full legal stream, both wraps included
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, sr_tab[i % 4], jt_tab[i % 8]);
            expect_out("stream", 1, i % 4, i % 8, 0, 0, 0, 1, 0, 0);
        end
        drive(1'b0, 4'b0000, 4'b0000);
        expect_out("stream_idle", 0, 3, 7, 0, 0, 0, 1, 0, 0);

        // Illegal Johnson code while locked, then illegal simple code in SYNC
        drive(1'b1, 4'b0001, 4'b0101);
        expect_out("ill_tr", 1, 0, 0, 0, 1, 1, 0, 1, 1);
        drive(1'b1, 4'b0011, 4'b0000);
        expect_out("ill_sr_sync", 1, 0, 0, 1, 0, 0, 0, 1, 1);
        drive(1'b0, 4'b0000, 4'b0000);
        expect_out("ill_hold", 0, 0, 0, 1, 0, 0, 0, 1, 1);

        // Sequence skip
        drive(1'b1, 4'b0010, 4'b0001);
        expect_out("skip_lock", 1, 1, 1, 0, 0, 0, 1, 1, 1);
        drive(1'b1, 4'b1000, 4'b0011);
        expect_out("skip_err", 1, 3, 2, 0, 0, 1, 0, 2, 2);
        drive(1'b1, 4'b0100, 4'b0011);
        expect_out("skip_relock", 1, 2, 2, 0, 0, 0, 1, 2, 2);

        // Valid gaps keep lock; stalled repeat breaks it
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0000, 4'b0000);
            expect_out("gap1", 0, 2, 2, 0, 0, 0, 1, 2, 2);
        end
        drive(1'b1, 4'b1000, 4'b0111);
        expect_out("gap_next", 1, 3, 3, 0, 0, 0, 1, 2, 2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0000, 4'b0000);
            expect_out("gap2", 0, 3, 3, 0, 0, 0, 1, 2, 2);
        end
        drive(1'b1, 4'b1000, 4'b0111);
        expect_out("stall", 1, 3, 3, 0, 0, 1, 0, 3, 3);

        // Further errors: saturating instance holds at 3
        drive(1'b1, 4'b0001, 4'b0000);
        expect_out("sat_lock1", 1, 0, 0, 0, 0, 0, 1, 3, 3);
        drive(1'b1, 4'b0001, 4'b0000);
        expect_out("sat_err4", 1, 0, 0, 0, 0, 1, 0, 4, 3);
        drive(1'b1, 4'b0010, 4'b0001);
        expect_out("sat_lock2", 1, 1, 1, 0, 0, 0, 1, 4, 3);
        // sr illegal and tr out of sequence together: one error only
        drive(1'b1, 4'b0000, 4'b0111);
        expect_out("sat_err5", 1, 0, 3, 1, 0, 1, 0, 5, 3);

        // Reset mid-sequence while locked; sample in reset cycle is discarded
        drive(1'b1, 4'b0100, 4'b0011);
        expect_out("pre_rst", 1, 2, 2, 0, 0, 0, 1, 5, 3);
        drive_rst(1'b1, 4'b1000, 4'b0111);
        expect_out("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1'b1, 4'b0001, 4'b1110);
        expect_out("post_rst", 1, 0, 5, 0, 0, 0, 1, 0, 0);
        drive(1'b1, 4'b0010, 4'b1100);
        expect_out("post_rst2", 1, 1, 6, 0, 0, 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
